uart_tx_serializer: RTL

UART transmit engine on the read side of the two-clock byte FIFO, clocked by tx_clock. It pops one byte at a time from the FIFO read port (read request, read data, empty flag) and serialises it onto tx_line. Frame format is 8N1 by default: one start bit, DATA_BITS data bits sent LSB first, then STOP_BITS stop bits. It is the transmit counterpart to the receive path that fills the FIFO.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, default bit period, line levels.
// Imported by the transmit serializer and its baud tick generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // 100 MHz core clock at 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: bit_end_o pulses every CLKS_PER_BIT cycles, bit_pre_end_o one cycle earlier.
// Latency: combinational decode of the count register; clear_i holds the count at zero.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic bit_end_o,
    output logic bit_pre_end_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end_o     = (cnt_q == LAST_CNT);
    assign bit_pre_end_o = (cnt_q == PRE_CNT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from the FIFO read port and shifts them out LSB first (start, data, stop).
// Latency: rd_req to byte_done is 1 + (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles; all outputs registered.
// Backpressure: one pop per frame, only when tx_enable && !fifo_empty; optional parity bit via UART_TX_PARITY_EN.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       tx_clock,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_req,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       byte_done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [0:0]           stop_idx_q, stop_idx_d;
    logic                 rd_req_q, rd_req_d;
    logic                 tx_line_q, tx_line_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end, bit_pre_end;
    logic                 baud_clear;
    logic                 last_stop_next;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign baud_clear = (state_q == IDLE) || (state_q == FETCH);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i        (tx_clock),
        .reset_i      (reset),
        .clear_i      (baud_clear),
        .bit_end_o    (bit_end),
        .bit_pre_end_o(bit_pre_end)
    );

    // Outputs are registered, so the final stop cycle is recognised one cycle ahead.
    assign last_stop_next = (state_q == STOP) && bit_pre_end && (stop_idx_q == STOP_LAST);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        rd_req_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (rd_req_q) begin
                    state_d = FETCH;
                end else if (tx_enable && !fifo_empty) begin
                    rd_req_d = 1'b1;
                end
            end
            FETCH: begin
                shift_d = fifo_data[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_data[DATA_BITS-1:0];
`endif
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        stop_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = '0;
                end
            end
`endif
            STOP: begin
                if (last_stop_next) begin
                    rd_req_d = tx_enable && !fifo_empty;
                end
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = rd_req_q ? FETCH : IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = last_stop_next;
        case (state_d)
            START:   tx_line_d = START_LEVEL;
            DATA:    tx_line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_line_d = parity_d;
`endif
            default: tx_line_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge tx_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= '0;
            rd_req_q   <= 1'b0;
            tx_line_q  <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            rd_req_q   <= rd_req_d;
            tx_line_q  <= tx_line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign fifo_rd_req = rd_req_q;
    assign tx_line     = tx_line_q;
    assign tx_busy     = busy_q;
    assign byte_done   = done_q;

endmodule
